bram_fifo: RTL and testbench

- FIFO controller that is the client side of the 256x16 simple dual-port `bram`.
- Accepts a ready/valid write stream and drives the BRAM write port.
- Drives the BRAM read port and presents data on a ready/valid read stream through one output register.
- Lets the rest of the Fomu design use BRAM as an elastic buffer, e.g. between UART and a processing core.

---
 rtl/bram_fifo.sv | 99 +++++++++
 tb/tb_bram_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo.sv
// rtl/bram_fifo.sv - ready/valid FIFO controller on a 256x16 simple dual-port BRAM.
// Optional BRAM_FIFO_LEVEL_EN adds a registered o_level occupancy output.
module bram_fifo #(
   parameter int ADDR_SZ = 8,
   parameter int DATA_SZ = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [DATA_SZ-1:0] i_data,
   output logic               o_ready,
   output logic               o_valid,
   output logic [DATA_SZ-1:0] o_data,
   input  logic               i_ready,
   output logic               o_wr_en,
   output logic [ADDR_SZ-1:0] o_waddr,
   output logic [DATA_SZ-1:0] o_wdata,
   output logic               o_rd_en,
   output logic [ADDR_SZ-1:0] o_raddr,
`ifdef BRAM_FIFO_LEVEL_EN
   output logic [ADDR_SZ:0]   o_level,
`endif
   input  logic [DATA_SZ-1:0] i_rdata
);

   localparam logic [ADDR_SZ:0] FULL_CNT = {1'b1, {ADDR_SZ{1'b0}}};

   logic [ADDR_SZ-1:0] wptr_q, wptr_d;
   logic [ADDR_SZ-1:0] rptr_q, rptr_d;
   logic [ADDR_SZ:0]   cnt_q, cnt_d;
   logic               pend_q, pend_d;
   logic               valid_q, valid_d;
   logic [DATA_SZ-1:0] data_q, data_d;
   logic               push, pop, rd_en;

   always_comb begin
      o_ready = (cnt_q != FULL_CNT);
      push    = i_valid & o_ready;
      pop     = valid_q & i_ready;
      // Only read when the output register is free by the time the data lands.
      rd_en   = (cnt_q != '0) & ~pend_q & (~valid_q | i_ready);

      wptr_d  = push  ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = rd_en ? rptr_q + 1'b1 : rptr_q;
      pend_d  = rd_en;
      cnt_d   = cnt_q + (ADDR_SZ+1)'(push) - (ADDR_SZ+1)'(rd_en);

      valid_d = valid_q;
      data_d  = data_q;
      if (pend_q) begin
         valid_d = 1'b1;
         data_d  = i_rdata;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_wr_en = push;
   assign o_waddr = wptr_q;
   assign o_wdata = i_data;
   assign o_rd_en = rd_en;
   assign o_raddr = rptr_q;

`ifdef BRAM_FIFO_LEVEL_EN
   logic [ADDR_SZ:0] level_q, level_d;

   always_comb begin
      level_d = cnt_d + (ADDR_SZ+1)'(pend_d) + (ADDR_SZ+1)'(valid_d);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) level_q <= '0;
      else       level_q <= level_d;
   end

   assign o_level = level_q;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// tb/tb_bram_fifo.sv - self-checking bench for bram_fifo with a behavioural BRAM.
module tb_bram_fifo;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [15:0] i_data = '0;
   logic        i_ready = 1'b0;
   logic        o_ready, o_valid, o_wr_en, o_rd_en;
   logic [15:0] o_data, o_wdata;
   logic [7:0]  o_waddr, o_raddr;
   logic [15:0] i_rdata = '0;
`ifdef BRAM_FIFO_LEVEL_EN
   logic [8:0]  o_level;
`endif

   logic [15:0] mem [256];

   int n_assert = 0;
   int n_fail   = 0;

   bram_fifo #(.ADDR_SZ(8), .DATA_SZ(16)) dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .i_ready (i_ready),
      .o_wr_en (o_wr_en),
      .o_waddr (o_waddr),
      .o_wdata (o_wdata),
      .o_rd_en (o_rd_en),
      .o_raddr (o_raddr),
`ifdef BRAM_FIFO_LEVEL_EN
      .o_level (o_level),
`endif
      .i_rdata (i_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_wr_en) mem[o_waddr] <= o_wdata;
      if (o_rd_en) i_rdata <= mem[o_raddr];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        r;
      logic        e_ready;
      logic        e_wr;
      logic [7:0]  e_waddr;
      logic        e_rd;
      logic [7:0]  e_raddr;
      logic        e_valid;
      logic [15:0] e_data;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int acc, got, cyc, k, wwrap, rwrap;
      bit seen;

      //          v  d        r  rdy wr waddr rd raddr vld data
      tbl[0] = '{1, 16'h0005, 0, 1,  1, 8'd0, 0, 8'd0, 0, 16'h0000};
      tbl[1] = '{0, 16'h0000, 0, 1,  0, 8'd1, 1, 8'd0, 0, 16'h0000};
      tbl[2] = '{0, 16'h0000, 0, 1,  0, 8'd1, 0, 8'd1, 0, 16'h0000};
      tbl[3] = '{0, 16'h0000, 0, 1,  0, 8'd1, 0, 8'd1, 1, 16'h0005};
      tbl[4] = '{0, 16'h0000, 1, 1,  0, 8'd1, 0, 8'd1, 1, 16'h0005};
      tbl[5] = '{0, 16'h0000, 0, 1,  0, 8'd1, 0, 8'd1, 0, 16'h0005};

      do_reset();
      @(negedge clk);
      chk("reset o_valid", 32'(o_valid), 0);
      chk("reset o_data",  32'(o_data),  0);
      chk("reset o_ready", 32'(o_ready), 1);
      chk("reset o_wr_en", 32'(o_wr_en), 0);
      chk("reset o_rd_en", 32'(o_rd_en), 0);
      chk("reset o_raddr", 32'(o_raddr), 0);
`ifdef BRAM_FIFO_LEVEL_EN
      chk("reset o_level", 32'(o_level), 0);
`endif
      next_cycle();

      for (int i = 0; i < 6; i++) begin
         i_valid = tbl[i].v;
         i_data  = tbl[i].d;
         i_ready = tbl[i].r;
         @(negedge clk);
         chk($sformatf("single[%0d] o_ready", i), 32'(o_ready), 32'(tbl[i].e_ready));
         chk($sformatf("single[%0d] o_wr_en", i), 32'(o_wr_en), 32'(tbl[i].e_wr));
         chk($sformatf("single[%0d] o_waddr", i), 32'(o_waddr), 32'(tbl[i].e_waddr));
         chk($sformatf("single[%0d] o_rd_en", i), 32'(o_rd_en), 32'(tbl[i].e_rd));
         chk($sformatf("single[%0d] o_raddr", i), 32'(o_raddr), 32'(tbl[i].e_raddr));
         chk($sformatf("single[%0d] o_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
         chk($sformatf("single[%0d] o_data",  i), 32'(o_data),  32'(tbl[i].e_data));
         next_cycle();
      end

      // Fill with the consumer stalled: BRAM depth plus the output register.
      do_reset();
      acc = 0;
      for (int c = 0; c < 300; c++) begin
         i_valid = 1'b1;
         i_data  = 16'(5 * (acc + 1));
         @(negedge clk);
         if (o_ready) acc++;
         next_cycle();
      end
      i_valid = 1'b0;
      @(negedge clk);
      chk("fill accepted", acc, 257);
      chk("fill o_ready",  32'(o_ready), 0);
      chk("fill o_valid",  32'(o_valid), 1);
      chk("fill o_data",   32'(o_data),  5);
`ifdef BRAM_FIFO_LEVEL_EN
      chk("fill o_level",  32'(o_level), 257);
`endif
      next_cycle();

      // Drain from full.
      i_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (cyc < 1000 && got < 257) begin
         @(negedge clk);
         if (cyc == 0) begin
            chk("drain first rd_en", 32'(o_rd_en), 1);
            chk("drain o_ready while full", 32'(o_ready), 0);
         end
         if (cyc == 1) chk("drain o_ready after issue", 32'(o_ready), 1);
         if (o_valid) begin
            chk($sformatf("drain word %0d", got), 32'(o_data), 5 * (got + 1));
            got++;
         end
         next_cycle();
         cyc++;
      end
      chk("drain count", got, 257);
      @(negedge clk);
      chk("drain end o_valid", 32'(o_valid), 0);
      chk("drain end o_ready", 32'(o_ready), 1);
      chk("drain end o_rd_en", 32'(o_rd_en), 0);
      next_cycle();

      // Continuous stream through both pointer wraps.
      do_reset();
      i_ready = 1'b1;
      k = 0; got = 0; cyc = 0; wwrap = 0; rwrap = 0;
      while (cyc < 4000 && got < 600) begin
         i_valid = (k < 600);
         i_data  = 16'(5 * k);
         @(negedge clk);
         if (o_wr_en && o_waddr == 8'd255) wwrap++;
         if (o_rd_en && o_raddr == 8'd255) rwrap++;
         if (i_valid && o_ready) k++;
         if (o_valid) begin
            if (o_data != 16'(5 * got)) chk($sformatf("stream word %0d", got), 32'(o_data), 5 * got);
            else n_assert++;
            got++;
         end
         next_cycle();
         cyc++;
      end
      i_valid = 1'b0;
      chk("stream received", got, 600);
      chk("stream pushed", k, 600);
      chk("stream write wraps", wwrap, 2);
      chk("stream read wraps", rwrap, 2);

      // Reset while a read is in flight.
      do_reset();
      for (int j = 0; j < 41; j++) begin
         i_valid = 1'b1;
         i_data  = 16'(5 * (j + 1));
         next_cycle();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      chk("mid pop rd_en", 32'(o_rd_en), 1);
      next_cycle();
      i_ready = 1'b0;
      i_rst   = 1'b1;
      next_cycle();
      i_rst   = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      chk("mid reset o_valid", 32'(o_valid), 0);
      chk("mid reset o_rd_en", 32'(o_rd_en), 0);
      chk("mid reset o_ready", 32'(o_ready), 1);
      chk("mid reset o_raddr", 32'(o_raddr), 0);
`ifdef BRAM_FIFO_LEVEL_EN
      chk("mid reset o_level", 32'(o_level), 0);
`endif
      next_cycle();
      i_valid = 1'b1;
      i_data  = 16'h00AA;
      next_cycle();
      i_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (o_valid) begin
            seen = 1'b1;
            chk("mid first output", 32'(o_data), 32'h00AA);
         end
         next_cycle();
      end
      if (!seen) chk("mid output timeout", 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
